packet_injector: RTL and testbench

//  Local-node injection stage sitting directly upstream of the router input FIFO.
//  - Accepts a packet request from the processing element (PE).
//  - Waits until the FIFO reports room for a whole packet (ordy).
//  - Builds a hypercube header flit, then streams PACKET_LEN-1 payload flits from the PE into the FIFO.
//  - Guarantees the FIFO never sees wr_en while it lacks space for the packet in flight.

---
 rtl/packet_injector.sv | 121 ++++++++++++
 tb/tb_packet_injector.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_injector.sv
// Local-node packet injector: waits until the router FIFO can take a whole packet,
// emits a hypercube header flit, then passes PACKET_LEN-1 PE payload flits straight through.
module packet_injector #(
    parameter int DATA_WIDTH = 32,
    parameter int PACKET_LEN = 4,
    parameter int DIM        = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DIM-1:0]        node_id_i,
    input  logic                  pkt_start_i,
    input  logic [DIM-1:0]        pkt_dest_i,
    output logic                  pkt_busy_o,
    output logic                  pkt_done_o,
    output logic                  pkt_err_o,
    input  logic                  pld_valid_i,
    input  logic [DATA_WIDTH-1:0] pld_data_i,
    output logic                  pld_ready_o,
    input  logic                  fifo_ordy_i,
    output logic                  fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0] fifo_idata_o
);

    localparam int PAD_W = DATA_WIDTH - 2*DIM - 8;
    localparam int CNT_W = (PACKET_LEN > 2) ? $clog2(PACKET_LEN - 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PACKET_LEN - 2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RDY,
        HEADER,
        PAYLOAD
    } state_e;

    state_e           state_q, state_d;
    logic [DIM-1:0]   dest_q, dest_d;
    logic [7:0]       seq_q, seq_d;
    logic [CNT_W-1:0] flitCnt_q, flitCnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            dest_q    <= '0;
            seq_q     <= '0;
            flitCnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            seq_q     <= seq_d;
            flitCnt_q <= flitCnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dest_d       = dest_q;
        seq_d        = seq_q;
        flitCnt_d    = flitCnt_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        pld_ready_o  = 1'b0;
        fifo_wr_en_o = 1'b0;
        fifo_idata_o = '0;

        case (state_q)
            IDLE: begin
                if (pkt_start_i) begin
                    if (pkt_dest_i == node_id_i) begin
                        err_d = 1'b1;
                    end else begin
                        dest_d  = pkt_dest_i;
                        state_d = WAIT_RDY;
                    end
                end
            end

            WAIT_RDY: begin
                if (fifo_ordy_i) begin
                    state_d = HEADER;
                end
            end

            HEADER: begin
                fifo_wr_en_o = 1'b1;
                fifo_idata_o = {dest_q, node_id_i, seq_q, {PAD_W{1'b0}}};
                flitCnt_d    = '0;
                state_d      = PAYLOAD;
            end

            PAYLOAD: begin
                // Space was reserved before the header, so fifo_ordy no longer gates writes.
                pld_ready_o  = 1'b1;
                fifo_wr_en_o = pld_valid_i;
                fifo_idata_o = pld_data_i;
                if (pld_valid_i) begin
                    flitCnt_d = flitCnt_q + CNT_W'(1);
                    if (flitCnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        seq_d   = seq_q + 8'd1;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pkt_busy_o = (state_q != IDLE);
    assign pkt_done_o = done_q;
    assign pkt_err_o  = err_q;

endmodule

// File: tb/tb_packet_injector.sv
// Randomized bench for packet_injector: drives PE/FIFO traffic and checks every FIFO write,
// timing and status pulse against a packet-level reference model.
module tb_packet_injector;

    localparam int DW   = 32;
    localparam int PLEN = 4;
    localparam int DIM  = 3;
    localparam logic [DIM-1:0] NODE = 3'd1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [DIM-1:0] node_id = NODE;
    logic           pkt_start = 1'b0;
    logic [DIM-1:0] pkt_dest = '0;
    logic           pkt_busy, pkt_done, pkt_err;
    logic           pld_valid = 1'b0;
    logic [DW-1:0]  pld_data = '0;
    logic           pld_ready;
    logic           fifo_ordy = 1'b1;
    logic           fifo_wr_en;
    logic [DW-1:0]  fifo_idata;

    int checks = 0;
    int errors = 0;
    int modelSeq = 0;

    logic [DW-1:0] obsWrites[$];
    logic [DW-1:0] sentPay[$];
    int headerCycle, lastWriteCycle, doneCycle, waitViol;
    bit timedOut;

    always #5 clk = ~clk;

    packet_injector #(.DATA_WIDTH(DW), .PACKET_LEN(PLEN), .DIM(DIM)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .node_id_i    (node_id),
        .pkt_start_i  (pkt_start),
        .pkt_dest_i   (pkt_dest),
        .pkt_busy_o   (pkt_busy),
        .pkt_done_o   (pkt_done),
        .pkt_err_o    (pkt_err),
        .pld_valid_i  (pld_valid),
        .pld_data_i   (pld_data),
        .pld_ready_o  (pld_ready),
        .fifo_ordy_i  (fifo_ordy),
        .fifo_wr_en_o (fifo_wr_en),
        .fifo_idata_o (fifo_idata)
    );

    // Header as the PE would expect it: dest, source, sequence, zero padding.
    function automatic logic [DW-1:0] expHeader(input logic [DIM-1:0] dest, input int seq);
        logic [7:0] s;
        s = seq[7:0];
        return {dest, NODE, s, {(DW-2*DIM-8){1'b0}}};
    endfunction

    function automatic logic [DIM-1:0] randDest();
        logic [DIM-1:0] d;
        d = DIM'($urandom_range(7));
        while (d == NODE) d = DIM'($urandom_range(7));
        return d;
    endfunction

    task automatic idle(input int n);
        pkt_start = 1'b0;
        pld_valid = 1'b0;
        fifo_ordy = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one packet request (cycle 0 = request cycle) and records what the FIFO saw.
    // Returns in the cycle pkt_done is seen, before the next clock edge.
    task automatic run_packet(input logic [DIM-1:0] dest, input int ordyDelay, input int gapPct,
                              input logic [7:0] mask, input int maskLen, input int abortAfter);
        int c, maskIdx, payIdx;
        bit finished;
        obsWrites.delete();
        sentPay.delete();
        for (int i = 0; i < PLEN-1; i++) sentPay.push_back(DW'($urandom()));
        headerCycle = -1; lastWriteCycle = -1; doneCycle = -1; waitViol = 0; timedOut = 1'b0;
        c = 0; maskIdx = 0; payIdx = 0; finished = 1'b0;
        while (!finished) begin
            pkt_start = (c == 0);
            pkt_dest  = dest;
            if (headerCycle < 0) fifo_ordy = (c > ordyDelay);
            else fifo_ordy = (gapPct > 0) ? 1'($urandom_range(1)) : 1'b1;
            if (pld_ready) begin
                if (maskIdx < maskLen) begin
                    pld_valid = mask[maskIdx];
                    maskIdx++;
                end else begin
                    pld_valid = (int'($urandom_range(99)) >= gapPct);
                end
            end else begin
                pld_valid = (gapPct > 0) ? 1'($urandom_range(1)) : 1'b0;
            end
            pld_data = (pld_ready && pld_valid && payIdx < sentPay.size()) ? sentPay[payIdx] : DW'($urandom());
            #1;
            if (c >= 1 && c <= ordyDelay + 1 && (fifo_wr_en || pld_ready || !pkt_busy)) waitViol++;
            if (fifo_wr_en) begin
                obsWrites.push_back(fifo_idata);
                if (headerCycle < 0) headerCycle = c;
                lastWriteCycle = c;
            end
            if (pld_valid && pld_ready) payIdx++;
            if (c > 0 && pkt_done) begin
                doneCycle = c;
                finished  = 1'b1;
            end else if (abortAfter > 0 && obsWrites.size() == abortAfter) begin
                finished = 1'b1;
            end else if (c >= 400) begin
                timedOut = 1'b1;
                finished = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                c++;
            end
        end
    endtask

    task automatic test_reset();
        pkt_start = 1'b1;
        pkt_dest  = 3'd5;
        pld_valid = 1'b1;
        pld_data  = 32'hDEAD_BEEF;
        fifo_ordy = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pkt_busy, pkt_done, pkt_err, fifo_wr_en, pld_ready} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b exp 00000", {pkt_busy, pkt_done, pkt_err, fifo_wr_en, pld_ready});
        end
        checks++;
        if (fifo_idata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_idata got %h exp 0", fifo_idata);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pkt_busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold got busy=%b wr=%b exp 0 0", pkt_busy, fifo_wr_en);
        end
        pkt_start = 1'b0;
        pld_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (pkt_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release_busy got %b exp 0", pkt_busy);
        end
        modelSeq = 0;
    endtask

    task automatic test_basic();
        logic [DW-1:0] got;
        run_packet(3'd6, 0, 0, 8'h00, 0, 0);
        checks++;
        if (timedOut !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout got %b exp 0", timedOut); end
        checks++;
        if (headerCycle !== 2) begin errors++; $display("[TB] FAIL basic_hdr_cycle got %0d exp 2", headerCycle); end
        checks++;
        if (obsWrites.size() !== PLEN) begin errors++; $display("[TB] FAIL basic_nwrites got %0d exp %0d", obsWrites.size(), PLEN); end
        got = (obsWrites.size() > 0) ? obsWrites[0] : 'x;
        checks++;
        if (got !== expHeader(3'd6, modelSeq)) begin errors++; $display("[TB] FAIL basic_header got %h exp %h", got, expHeader(3'd6, modelSeq)); end
        for (int i = 1; i < PLEN; i++) begin
            got = (i < obsWrites.size()) ? obsWrites[i] : 'x;
            checks++;
            if (got !== sentPay[i-1]) begin errors++; $display("[TB] FAIL basic_payload%0d got %h exp %h", i, got, sentPay[i-1]); end
        end
        checks++;
        if (lastWriteCycle !== headerCycle + PLEN - 1) begin errors++; $display("[TB] FAIL basic_contig got %0d exp %0d", lastWriteCycle, headerCycle + PLEN - 1); end
        checks++;
        if (doneCycle !== lastWriteCycle + 1) begin errors++; $display("[TB] FAIL basic_done_cycle got %0d exp %0d", doneCycle, lastWriteCycle + 1); end
        modelSeq = (modelSeq + 1) % 256;
        idle(1);
        checks++;
        if ({pkt_done, pkt_busy} !== 2'b00) begin errors++; $display("[TB] FAIL basic_done_pulse got %b exp 00", {pkt_done, pkt_busy}); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] got;
        idle(1);
        run_packet(3'd4, 10, 0, 8'h00, 0, 0);
        checks++;
        if (waitViol !== 0) begin errors++; $display("[TB] FAIL bp_wait_violations got %0d exp 0", waitViol); end
        checks++;
        if (headerCycle !== 12) begin errors++; $display("[TB] FAIL bp_hdr_cycle got %0d exp 12", headerCycle); end
        got = (obsWrites.size() > 0) ? obsWrites[0] : 'x;
        checks++;
        if (got !== expHeader(3'd4, modelSeq)) begin errors++; $display("[TB] FAIL bp_header got %h exp %h", got, expHeader(3'd4, modelSeq)); end
        checks++;
        if (obsWrites.size() !== PLEN) begin errors++; $display("[TB] FAIL bp_nwrites got %0d exp %0d", obsWrites.size(), PLEN); end
        modelSeq = (modelSeq + 1) % 256;
    endtask

    task automatic test_gaps();
        logic [DW-1:0] got;
        idle(2);
        run_packet(3'd7, 0, 0, 8'b0001_1001, 5, 0);
        checks++;
        if (obsWrites.size() !== PLEN) begin errors++; $display("[TB] FAIL gaps_nwrites got %0d exp %0d", obsWrites.size(), PLEN); end
        for (int i = 1; i < PLEN; i++) begin
            got = (i < obsWrites.size()) ? obsWrites[i] : 'x;
            checks++;
            if (got !== sentPay[i-1]) begin errors++; $display("[TB] FAIL gaps_payload%0d got %h exp %h", i, got, sentPay[i-1]); end
        end
        checks++;
        if (lastWriteCycle !== headerCycle + 5) begin errors++; $display("[TB] FAIL gaps_last_write got %0d exp %0d", lastWriteCycle, headerCycle + 5); end
        checks++;
        if (doneCycle !== lastWriteCycle + 1) begin errors++; $display("[TB] FAIL gaps_done_cycle got %0d exp %0d", doneCycle, lastWriteCycle + 1); end
        modelSeq = (modelSeq + 1) % 256;
    endtask

    task automatic test_self_addr();
        logic [DW-1:0] got;
        idle(1);
        pkt_start = 1'b1;
        pkt_dest  = NODE;
        @(posedge clk);
        #1;
        pkt_start = 1'b0;
        checks++;
        if ({pkt_err, pkt_busy, fifo_wr_en} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL self_err_pulse got err/busy/wr=%b exp 100", {pkt_err, pkt_busy, fifo_wr_en});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({pkt_err, pkt_busy} !== 2'b00) begin errors++; $display("[TB] FAIL self_err_clear got %b exp 00", {pkt_err, pkt_busy}); end
        run_packet(3'd5, 0, 0, 8'h00, 0, 0);
        got = (obsWrites.size() > 0) ? obsWrites[0] : 'x;
        checks++;
        if (got !== expHeader(3'd5, modelSeq)) begin errors++; $display("[TB] FAIL self_next_header got %h exp %h", got, expHeader(3'd5, modelSeq)); end
        modelSeq = (modelSeq + 1) % 256;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] got;
        idle(1);
        run_packet(3'd2, 0, 0, 8'h00, 0, 0);
        checks++;
        if (doneCycle !== lastWriteCycle + 1) begin errors++; $display("[TB] FAIL b2b_first_done got %0d exp %0d", doneCycle, lastWriteCycle + 1); end
        modelSeq = (modelSeq + 1) % 256;
        run_packet(3'd3, 0, 0, 8'h00, 0, 0);
        checks++;
        if (headerCycle !== 2) begin errors++; $display("[TB] FAIL b2b_second_hdr_cycle got %0d exp 2", headerCycle); end
        got = (obsWrites.size() > 0) ? obsWrites[0] : 'x;
        checks++;
        if (got !== expHeader(3'd3, modelSeq)) begin errors++; $display("[TB] FAIL b2b_second_header got %h exp %h", got, expHeader(3'd3, modelSeq)); end
        modelSeq = (modelSeq + 1) % 256;
    endtask

    task automatic test_random();
        logic [DIM-1:0] d;
        int dly;
        logic [DW-1:0] got;
        for (int p = 0; p < 24; p++) begin
            idle($urandom_range(2));
            d   = randDest();
            dly = $urandom_range(5);
            run_packet(d, dly, 30, 8'h00, 0, 0);
            checks++;
            if (headerCycle !== dly + 2 || waitViol !== 0) begin
                errors++;
                $display("[TB] FAIL rand%0d_timing got hdr=%0d viol=%0d exp hdr=%0d viol=0", p, headerCycle, waitViol, dly + 2);
            end
            checks++;
            if (obsWrites.size() !== PLEN) begin errors++; $display("[TB] FAIL rand%0d_nwrites got %0d exp %0d", p, obsWrites.size(), PLEN); end
            got = (obsWrites.size() > 0) ? obsWrites[0] : 'x;
            checks++;
            if (got !== expHeader(d, modelSeq)) begin errors++; $display("[TB] FAIL rand%0d_header got %h exp %h", p, got, expHeader(d, modelSeq)); end
            for (int i = 1; i < PLEN; i++) begin
                got = (i < obsWrites.size()) ? obsWrites[i] : 'x;
                checks++;
                if (got !== sentPay[i-1]) begin errors++; $display("[TB] FAIL rand%0d_payload%0d got %h exp %h", p, i, got, sentPay[i-1]); end
            end
            checks++;
            if (doneCycle !== lastWriteCycle + 1) begin errors++; $display("[TB] FAIL rand%0d_done got %0d exp %0d", p, doneCycle, lastWriteCycle + 1); end
            modelSeq = (modelSeq + 1) % 256;
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] got;
        idle(1);
        run_packet(3'd2, 0, 0, 8'h00, 0, 2);
        checks++;
        if (obsWrites.size() !== 2) begin errors++; $display("[TB] FAIL arst_prefix_writes got %0d exp 2", obsWrites.size()); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pkt_busy, pkt_done, pkt_err, fifo_wr_en, pld_ready} !== 5'b0 || fifo_idata !== '0) begin
            errors++;
            $display("[TB] FAIL arst_outputs got ctrl=%b data=%h exp 00000 0",
                     {pkt_busy, pkt_done, pkt_err, fifo_wr_en, pld_ready}, fifo_idata);
        end
        pkt_start = 1'b0;
        pld_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        modelSeq = 0;
        run_packet(3'd7, 0, 0, 8'h00, 0, 0);
        got = (obsWrites.size() > 0) ? obsWrites[0] : 'x;
        checks++;
        if (got !== expHeader(3'd7, 0)) begin errors++; $display("[TB] FAIL arst_next_header got %h exp %h", got, expHeader(3'd7, 0)); end
        modelSeq = (modelSeq + 1) % 256;
    endtask

    task automatic test_seq_wrap();
        logic [DIM-1:0] d;
        logic [DW-1:0] h;
        logic [7:0] seqField;
        idle(1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        modelSeq = 0;
        for (int p = 1; p <= 257; p++) begin
            d = randDest();
            run_packet(d, 0, 0, 8'h00, 0, 0);
            h = (obsWrites.size() > 0) ? obsWrites[0] : 'x;
            seqField = h[DW-2*DIM-1 -: 8];
            checks++;
            if (h !== expHeader(d, modelSeq)) begin errors++; $display("[TB] FAIL wrap_pkt%0d_header got %h exp %h", p, h, expHeader(d, modelSeq)); end
            if (p == 256) begin
                checks++;
                if (seqField !== 8'd255) begin errors++; $display("[TB] FAIL wrap_seq256 got %0d exp 255", seqField); end
            end
            if (p == 257) begin
                checks++;
                if (seqField !== 8'd0) begin errors++; $display("[TB] FAIL wrap_seq257 got %0d exp 0", seqField); end
            end
            modelSeq = (modelSeq + 1) % 256;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_self_addr();
        test_back_to_back();
        test_random();
        test_async_reset();
        test_seq_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
